// File: rtl/axis_packet_tx.sv
// Packetising AXI4-Stream master: buffers words in a FIFO, sends packets of pkt_len beats.
// Define AXIS_PACKET_TX_OVF_EN to enable the sticky in_overflow (dropped-write) flag.
module axis_packet_tx #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int PKT_LEN_WIDTH = 8
) (
    input  logic                      m01_axis_aclk,
    input  logic                      m01_axis_aresetn,
    input  logic                      in_wr_en,
    input  logic [DATA_WIDTH-1:0]     in_wr_data,
    output logic                      in_full,
    input  logic [PKT_LEN_WIDTH-1:0]  pkt_len,
    output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
    output logic                      m01_axis_tvalid,
    output logic                      m01_axis_tlast,
    input  logic                      m01_axis_tready,
    output logic                      busy,
    output logic [15:0]               pkt_count,
    output logic                      in_overflow
);

    // Handshake: a beat transfers on a rising edge where tvalid and tready are both 1;
    // once tvalid rises it stays high, with tdata/tlast/tstrb frozen, until that transfer.

    localparam int CW = ADDR_WIDTH + 1;
    localparam int LW = (PKT_LEN_WIDTH > CW) ? PKT_LEN_WIDTH : CW;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          rem;
    logic [CW-1:0]          rem_next;
    logic [CW-1:0]          eff_len;
    logic [LW-1:0]          len_ext;
    logic                   full;
    logic                   wr_accept;
    logic                   pop;
    logic                   last_beat;
    logic [15:0]            pkt_cnt;

    assign full      = (count == DEPTH_C);
    assign wr_accept = in_wr_en && !full;
    assign pop       = (state == SEND) && m01_axis_tready;
    assign last_beat = (state == SEND) && (rem == ONE_C);

    // Zero means a single beat; anything longer than the FIFO could never start.
    always_comb begin
        len_ext = LW'(pkt_len);
        eff_len = ONE_C;
        if (len_ext == '0) begin
            eff_len = ONE_C;
        end else if (len_ext > DEPTH_L) begin
            eff_len = DEPTH_C;
        end else begin
            eff_len = CW'(len_ext);
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        case (state)
            IDLE: begin
                if (count >= eff_len) begin
                    state_next = SEND;
                    rem_next   = eff_len;
                end
            end
            SEND: begin
                if (pop) begin
                    rem_next = rem - ONE_C;
                    if (rem == ONE_C) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    // Storage carries no reset; pointers and occupancy define what is valid.
    always_ff @(posedge m01_axis_aclk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= in_wr_data;
        end
    end

    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            pkt_cnt <= '0;
        end else if (pop && last_beat) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

`ifdef AXIS_PACKET_TX_OVF_EN
    logic ovf;

    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            ovf <= 1'b0;
        end else if (in_wr_en && full) begin
            ovf <= 1'b1;
        end
    end

    assign in_overflow = ovf;
`else
    assign in_overflow = 1'b0;
`endif

    // Outputs are decoded from registered state so reset clears them immediately.
    assign in_full         = full;
    assign busy            = (state == SEND);
    assign m01_axis_tvalid = (state == SEND);
    assign m01_axis_tlast  = last_beat;
    assign m01_axis_tdata  = (state == SEND) ? mem[rd_ptr] : '0;
    assign m01_axis_tstrb  = {(DATA_WIDTH/8){state == SEND}};
    assign pkt_count       = pkt_cnt;

endmodule

// File: tb/tb_axis_packet_tx.sv
// Self-checking bench for axis_packet_tx: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based packet model.
module tb_axis_packet_tx;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int STRB  = W / 8;
    localparam logic [STRB-1:0] ALL_STRB = '1;
`ifdef AXIS_PACKET_TX_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_wr_en;
    logic [W-1:0]    in_wr_data;
    logic            in_full;
    logic [7:0]      pkt_len;
    logic [W-1:0]    tdata;
    logic [STRB-1:0] tstrb;
    logic            tvalid;
    logic            tlast;
    logic            tready;
    logic            busy;
    logic [15:0]     pkt_count;
    logic            in_overflow;

    axis_packet_tx #(
        .DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(4), .PKT_LEN_WIDTH(8)
    ) dut (
        .m01_axis_aclk(clk),
        .m01_axis_aresetn(rst_n),
        .in_wr_en(in_wr_en),
        .in_wr_data(in_wr_data),
        .in_full(in_full),
        .pkt_len(pkt_len),
        .m01_axis_tdata(tdata),
        .m01_axis_tstrb(tstrb),
        .m01_axis_tvalid(tvalid),
        .m01_axis_tlast(tlast),
        .m01_axis_tready(tready),
        .busy(busy),
        .pkt_count(pkt_count),
        .in_overflow(in_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0] exp_q[$];
    int           total  = 0;
    int           passed = 0;
    int           occ_now = 0;
    logic         m_send = 1'b0;
    int           m_rem  = 0;
    logic [15:0]  m_cnt  = '0;
    logic         m_ovf  = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         prev_last  = 1'b0;

    function automatic int eff(input int p);
        if (p == 0) return 1;
        if (p > DEPTH) return DEPTH;
        return p;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void fail_now(input string name);
        total++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    // Occupancy the DUT holds during the current cycle.
    always @(posedge clk) begin
        #1 occ_now = exp_q.size();
    end

    // Monitor: compare this cycle's outputs with the model, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_send = 1'b0; m_rem = 0; m_cnt = '0; m_ovf = 1'b0;
            prev_stall = 1'b0; occ_now = 0;
        end else begin
            chk("tvalid", 64'(tvalid), 64'(m_send));
            chk("busy", 64'(busy), 64'(m_send));
            chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
            chk("in_full", 64'(in_full), 64'(occ_now == DEPTH));
            chk("in_overflow", 64'(in_overflow), 64'(m_ovf));
            if (prev_stall) begin
                chk("stall_tdata", 64'(tdata), 64'(prev_data));
                chk("stall_tlast", 64'(tlast), 64'(prev_last));
            end
            if (m_send) begin
                chk("tlast", 64'(tlast), 64'(m_rem == 1));
                chk("tstrb", 64'(tstrb), 64'(ALL_STRB));
            end else begin
                chk("idle_tdata", 64'(tdata), 64'(0));
                chk("idle_tlast", 64'(tlast), 64'(0));
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (m_send && tready) begin
                if (exp_q.size() == 0) begin
                    fail_now("beat_without_data");
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("tdata", 64'(tdata), 64'(e));
                end
                m_rem--;
                if (m_rem == 0) begin
                    m_send = 1'b0;
                    m_cnt  = m_cnt + 16'd1;
                end
            end else if (!m_send && occ_now >= eff(int'(pkt_len))) begin
                m_send = 1'b1;
                m_rem  = eff(int'(pkt_len));
            end
`ifdef AXIS_PACKET_TX_OVF_EN
            if (in_wr_en && occ_now == DEPTH) m_ovf = 1'b1;
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        in_wr_en   = 1'b1;
        in_wr_data = d;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        tick();
        in_wr_en = 1'b0;
    endtask

    task automatic wait_send();
        int n = 0;
        while (!m_send && n < 50) begin tick(); n++; end
        if (!m_send) fail_now("wait_send_timeout");
    endtask

    task automatic wait_drain();
        int n = 0;
        in_wr_en = 1'b0;
        tready   = 1'b1;
        while ((exp_q.size() != 0 || m_send) && n < 300) begin tick(); n++; end
        if (exp_q.size() != 0 || m_send) fail_now("drain_timeout");
        tick();
    endtask

    task automatic reset_now();
        in_wr_en = 1'b0;
        tready   = 1'b0;
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_tdata", 64'(tdata), 64'(0));
        chk("rst_tlast", 64'(tlast), 64'(0));
        chk("rst_in_full", 64'(in_full), 64'(0));
        chk("rst_in_overflow", 64'(in_overflow), 64'(0));
        chk("rst_tstrb", 64'(tstrb), 64'(0));
        @(posedge clk);
        in_wr_en = 1'b1;   // must be ignored while reset is held
        @(posedge clk);
        #2;
        in_wr_en = 1'b0;
        rst_n    = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; in_wr_en = 1'b0; in_wr_data = '0; pkt_len = 8'd4; tready = 1'b0;
        #3;
        reset_now();

        // four-beat packet, always ready
        pkt_len = 8'd4; tready = 1'b1;
        write_word(32'h11); write_word(32'h22); write_word(32'h33); write_word(32'h44);
        wait_drain();
        chk("first_pkt_count", 64'(pkt_count), 64'(1));

        // three-beat packet with stalls
        pkt_len = 8'd3; tready = 1'b0;
        write_word(32'h101); write_word(32'h102); write_word(32'h103);
        wait_send();
        begin
            logic [5:0] pat;
            pat = 6'b101001;
            for (int i = 0; i < 6; i++) begin
                tready = pat[i];
                tick();
            end
        end
        tready = 1'b0;
        tick();
        chk("stall_pkt_done", 64'(busy), 64'(0));
        wait_drain();

        // zero length -> single beat; oversize length -> full-depth packet
        pkt_len = 8'd0; tready = 1'b1;
        write_word(32'hA5);
        wait_drain();
        pkt_len = 8'd40; tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(32'h200 + 32'(i));
        wait_drain();

        // overfill with a stalled sink
        pkt_len = 8'd20; tready = 1'b0;
        for (int i = 0; i < 17; i++) write_word(32'h300 + 32'(i));
        chk("full_after_16", 64'(in_full), 64'(1));
        chk("overflow_flag", 64'(in_overflow), 64'(OVF_EXP));
        wait_drain();
        chk("overflow_sticky", 64'(in_overflow), 64'(OVF_EXP));

        // reset in the middle of a packet, then a clean packet
        pkt_len = 8'd4; tready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(32'h400 + 32'(i));
        wait_send();
        tready = 1'b1;
        tick(); tick();
        reset_now();
        tready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(32'h500 + 32'(i));
        wait_drain();
        chk("post_reset_pkt", 64'(pkt_count), 64'(1));

        // back-to-back packets while writing, pointers wrap
        pkt_len = 8'd4; tready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(32'h600 + 32'(i));
        wait_drain();

        // random traffic in phases of varying sink readiness
        for (int ph = 0; ph < 3; ph++) begin
            int rdy_pct;
            rdy_pct = (ph == 0) ? 80 : ((ph == 1) ? 20 : 55);
            for (int c = 0; c < 600; c++) begin
                in_wr_en   = ($urandom_range(0, 99) < 65);
                in_wr_data = $urandom;
                tready     = ($urandom_range(0, 99) < rdy_pct);
                if ($urandom_range(0, 31) == 0) pkt_len = 8'($urandom_range(0, 20));
                if (in_wr_en && exp_q.size() < DEPTH) exp_q.push_back(in_wr_data);
                tick();
            end
        end
        pkt_len = 8'd1;
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
